// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one shift-add micro-rotation stage reused ITERATIONS times per sample.
// Latency: a sample accepted at edge E0 gives valid_o from edge E0+ITERATIONS. Throughput is 1 sample per ITERATIONS+2 cycles.
// Backpressure: ready_o is high only in IDLE. The result is held stable in DONE until ready_i; upstream valid_i is never buffered.
//
// Ports:
//   clk_i, rstn_i             clock, synchronous active-low reset
//   valid_i/ready_o           input handshake for x_i, y_i (DW, signed) and a_i (AW, signed, 2^(AW-1) = pi)
//   valid_o/ready_i           output handshake for x_o, y_o (DW, signed) and a_o (AW, signed)
// MODE "rotation" drives the angle register to zero. MODE "vectoring" drives y to zero, and the angle
// register then accumulates the vector angle, so a_o = a_i + atan2(y_i, x_i). No gain compensation (K ~ 1.6468).
module cordic_iter_engine #(
    parameter int    DW         = 16,
    parameter int    AW         = 16,
    parameter int    ITERATIONS = 14,
    parameter string MODE       = "rotation"
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [AW-1:0] a_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [AW-1:0] a_o
);

    localparam int CW        = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam bit VECTORING = (MODE == "vectoring");
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);
    localparam real PI = 3.14159265358979323846;

    typedef logic [ITERATIONS-1:0][AW-1:0] atan_tbl_t;

    // ATAN[i] = round(atan(2^-i) * 2^(AW-1) / pi), evaluated at elaboration.
    function automatic atan_tbl_t build_atan();
        atan_tbl_t tbl;
        real       t;
        real       full;
        full = 1.0;
        for (int k = 0; k < AW - 1; k++) begin
            full = full * 2.0;
        end
        t = 1.0;
        for (int i = 0; i < ITERATIONS; i++) begin
            tbl[i] = AW'($rtoi($atan(t) * full / PI + 0.5));
            t = t / 2.0;
        end
        return tbl;
    endfunction

    localparam atan_tbl_t ATAN = build_atan();

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [DW-1:0]  x_q, x_d;
    logic signed [DW-1:0]  y_q, y_d;
    logic signed [AW-1:0]  a_q, a_d;
    // Holds ready_o low for the reset cycles themselves; set by the first edge after release.
    logic                  live_q, live_d;

    logic signed [DW-1:0]  x_sh;
    logic signed [DW-1:0]  y_sh;
    logic signed [AW-1:0]  at;
    logic                  ccw;

    // Single shared micro-rotation stage; the counter picks the shift and the table entry.
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        at   = $signed(ATAN[cnt_q]);
        // Counter-clockwise step when the residual angle is non-negative (rotation)
        // or when the vector sits below the x axis (vectoring).
        ccw  = VECTORING ? y_q[DW-1] : ~a_q[AW-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        a_d     = a_q;
        live_d  = 1'b1;
        ready_o = 1'b0;
        valid_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_o = live_q;
                if (valid_i && live_q) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    a_d     = a_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ccw) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    a_d = a_q - at;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    a_d = a_q + at;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            live_q  <= live_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign a_o = a_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine: one rotation-mode and one vectoring-mode instance.
// Expected values are hand-derived (ideal CORDIC results with tolerance, plus bit-exact
// traces) and a small independent rotation model for the back-to-back stream.
module tb_cordic_iter_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic               r_valid_i, r_ready_o, r_valid_o, r_ready_i;
    logic signed [15:0] r_x_i, r_y_i, r_a_i, r_x_o, r_y_o, r_a_o;
    logic               v_valid_i, v_ready_o, v_valid_o, v_ready_i;
    logic signed [15:0] v_x_i, v_y_i, v_a_i, v_x_o, v_y_o, v_a_o;

    cordic_iter_engine #(.DW(16), .AW(16), .ITERATIONS(14), .MODE("rotation")) u_rot (
        .clk_i(clk), .rstn_i(rstn),
        .valid_i(r_valid_i), .ready_o(r_ready_o),
        .x_i(r_x_i), .y_i(r_y_i), .a_i(r_a_i),
        .valid_o(r_valid_o), .ready_i(r_ready_i),
        .x_o(r_x_o), .y_o(r_y_o), .a_o(r_a_o)
    );

    cordic_iter_engine #(.DW(16), .AW(16), .ITERATIONS(14), .MODE("vectoring")) u_vec (
        .clk_i(clk), .rstn_i(rstn),
        .valid_i(v_valid_i), .ready_o(v_ready_o),
        .x_i(v_x_i), .y_i(v_y_i), .a_i(v_a_i),
        .valid_o(v_valid_o), .ready_i(v_ready_i),
        .x_o(v_x_o), .y_o(v_y_o), .a_o(v_a_o)
    );

    localparam int ATAN_TBL [14] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int act, input int exp, input int tol = 0);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, act, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent rotation-mode reference: 16-bit wrap, arithmetic shifts.
    function automatic void model_rot(input int xi, input int yi, input int ai,
                                      output int xo, output int yo, output int ao);
        logic signed [15:0] x, y, a, xs, ys, t;
        x = xi[15:0];
        y = yi[15:0];
        a = ai[15:0];
        for (int i = 0; i < 14; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            t  = ATAN_TBL[i][15:0];
            if (a < 0) begin
                x = x + ys;
                y = y - xs;
                a = a + t;
            end else begin
                x = x - ys;
                y = y + xs;
                a = a - t;
            end
        end
        xo = x;
        yo = y;
        ao = a;
    endfunction

    task automatic rot_send(input int x, input int y, input int a);
        int n;
        r_x_i = x[15:0];
        r_y_i = y[15:0];
        r_a_i = a[15:0];
        r_valid_i = 1'b1;
        n = 0;
        while (!r_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("rot_ready_before_accept", int'(r_ready_o), 1);
        tick();
        r_valid_i = 1'b0;
    endtask

    task automatic rot_wait(output int lat);
        lat = 0;
        while (!r_valid_o && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    int bx [3] = '{10000, -8000, 5000};
    int by [3] = '{0, 3000, -7000};
    int ba [3] = '{8192, 5000, -12000};

    int   lat, cyc, nacc, nres, ex, ey, ea, ox, oy, oa;
    int   acc_cyc [3];
    logic do_acc, do_res;

    initial begin
        rstn = 1'b0;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_x_i = '0; r_y_i = '0; r_a_i = '0;
        v_valid_i = 1'b0; v_ready_i = 1'b0; v_x_i = '0; v_y_i = '0; v_a_i = '0;
        acc_cyc = '{0, 0, 0};

        // Reset state
        tick(); tick(); tick();
        check("rst_rot_ready", int'(r_ready_o), 0);
        check("rst_vec_ready", int'(v_ready_o), 0);
        check("rst_rot_valid", int'(r_valid_o), 0);
        check("rst_rot_x", r_x_o, 0);
        check("rst_rot_y", r_y_o, 0);
        check("rst_rot_a", r_a_o, 0);
        rstn = 1'b1;
        tick();
        check("rel_rot_ready", int'(r_ready_o), 1);
        check("rel_vec_ready", int'(v_ready_o), 1);

        // Rotation by +pi/4
        r_ready_i = 1'b1;
        rot_send(10000, 0, 8192);
        rot_wait(lat);
        check("rot45_latency", lat, 14);
        check("rot45_x", r_x_o, 11645, 16);
        check("rot45_y", r_y_o, 11645, 16);
        check("rot45_a", r_a_o, 0, 4);
        tick();
        check("rot45_valid_one_cycle", int'(r_valid_o), 0);
        check("rot45_ready_after", int'(r_ready_o), 1);

        // Vectoring of (3000, 4000)
        v_ready_i = 1'b1;
        v_x_i = 16'sd3000; v_y_i = 16'sd4000; v_a_i = 16'sd0;
        v_valid_i = 1'b1;
        check("vec_ready_before_accept", int'(v_ready_o), 1);
        tick();
        v_valid_i = 1'b0;
        lat = 0;
        while (!v_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        check("vec_latency", lat, 14);
        check("vec_x", v_x_o, 8234, 16);
        check("vec_y", v_y_o, 0, 16);
        check("vec_a", v_a_o, 9672, 16);
        tick();

        // Back-pressure: hold the result for 10 cycles; valid_i pulses must be ignored
        r_ready_i = 1'b0;
        rot_send(10000, 0, 8192);
        rot_wait(lat);
        check("bp_latency", lat, 14);
        for (int k = 0; k < 10; k++) begin
            r_valid_i = k[0];
            r_x_i = 16'sd1234; r_y_i = 16'sd2345; r_a_i = -16'sd500;
            check("bp_valid", int'(r_valid_o), 1);
            check("bp_ready", int'(r_ready_o), 0);
            check("bp_x", r_x_o, 11645);
            check("bp_y", r_y_o, 11645);
            check("bp_a", r_a_o, 1);
            tick();
        end
        r_valid_i = 1'b0;
        r_ready_i = 1'b1;
        tick();
        check("bp_rel_valid", int'(r_valid_o), 0);
        check("bp_rel_ready", int'(r_ready_o), 1);
        tick();
        check("bp_no_buffered_accept", int'(r_ready_o), 1);

        // Rotation by -pi/2
        rot_send(10000, 0, -16384);
        rot_wait(lat);
        check("rotm90_latency", lat, 14);
        check("rotm90_x", r_x_o, 0, 16);
        check("rotm90_y", r_y_o, -16468, 16);
        tick();

        // Reset in the middle of RUN (after 5 micro-rotations)
        rot_send(10000, 0, 8192);
        for (int k = 0; k < 5; k++) tick();
        check("midrun_not_done", int'(r_valid_o), 0);
        rstn = 1'b0;
        tick();
        check("midrst_valid", int'(r_valid_o), 0);
        check("midrst_ready", int'(r_ready_o), 0);
        check("midrst_x", r_x_o, 0);
        check("midrst_y", r_y_o, 0);
        check("midrst_a", r_a_o, 0);
        rstn = 1'b1;
        tick();
        check("midrst_rel_ready", int'(r_ready_o), 1);
        check("midrst_rel_valid", int'(r_valid_o), 0);
        rot_send(10000, 0, -16384);
        rot_wait(lat);
        check("post_rst_latency", lat, 14);
        check("post_rst_x", r_x_o, 0, 16);
        check("post_rst_y", r_y_o, -16468, 16);
        tick();

        // Back-to-back stream with valid_i held high
        r_ready_i = 1'b1;
        nacc = 0; nres = 0; cyc = 0;
        r_x_i = bx[0][15:0]; r_y_i = by[0][15:0]; r_a_i = ba[0][15:0];
        r_valid_i = 1'b1;
        while (nres < 3 && cyc < 200) begin
            do_acc = r_valid_i && r_ready_o;
            do_res = r_valid_o;
            ox = r_x_o; oy = r_y_o; oa = r_a_o;
            tick();
            cyc++;
            if (do_acc) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    r_x_i = bx[nacc][15:0]; r_y_i = by[nacc][15:0]; r_a_i = ba[nacc][15:0];
                end else begin
                    r_valid_i = 1'b0;
                end
            end
            if (do_res) begin
                model_rot(bx[nres], by[nres], ba[nres], ex, ey, ea);
                check("b2b_x", ox, ex);
                check("b2b_y", oy, ey);
                check("b2b_a", oa, ea);
                nres++;
            end
        end
        r_valid_i = 1'b0;
        check("b2b_result_count", nres, 3);
        check("b2b_accept_count", nacc, 3);
        check("b2b_gap_0_1", acc_cyc[1] - acc_cyc[0], 16);
        check("b2b_gap_1_2", acc_cyc[2] - acc_cyc[1], 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
